// File: rtl/udiv_pkg.sv
// udiv_pkg: shared types and constants for the sequential 12/6 unsigned divider.
//   state_t    - controller states (IDLE, CALC, DONE)
//   DIVIDEND_W - dividend / quotient width
//   DIVISOR_W  - divisor / remainder width
//   CNT_W      - iteration counter width (holds 0..DIVIDEND_W)
//   QUOT_ONES  - quotient reported for a zero divisor
package udiv_pkg;

    localparam int DIVIDEND_W = 12;
    localparam int DIVISOR_W  = 6;
    localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

    localparam logic [DIVIDEND_W-1:0] QUOT_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_udiv_12_6_step.sv
// udiv_step: one combinational restoring-division step.
//   rem_in  - current partial remainder (always < divisor)
//   bit_in  - next dividend bit shifted into the remainder
//   divisor - divisor
//   rem_out - next partial remainder
//   q_bit   - resolved quotient bit
module udiv_step
    import udiv_pkg::*;
(
    input  logic [DIVISOR_W-1:0] rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] t;
    logic [DIVISOR_W:0] diff;

    always_comb begin
        t    = {rem_in, bit_in};
        diff = t - {1'b0, divisor};
        // The trial value needs one extra bit; the result is below the
        // divisor again, so it fits back into DIVISOR_W bits.
        if (t >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            rem_out = diff[DIVISOR_W-1:0];
        end else begin
            q_bit   = 1'b0;
            rem_out = t[DIVISOR_W-1:0];
        end
    end

endmodule

// File: rtl/seq_udiv_12_6.sv
// seq_udiv_12_6: sequential unsigned restoring divider, 12-bit dividend by
// 6-bit divisor, one quotient bit per clock.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (ready only while idle)
//   dividend, divisor    - unsigned operands
//   out_valid/out_ready  - result handshake (result held until taken)
//   quotient, remainder  - unsigned results
//   div_zero             - result came from a zero divisor
module seq_udiv_12_6
    import udiv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] q_reg;
    logic [DIVISOR_W-1:0]  r_reg;
    logic [DIVISOR_W-1:0]  d_reg;
    logic                  dz_reg;
    logic [DIVISOR_W-1:0]  r_next;
    logic                  q_bit;

    // q_reg doubles as the dividend shift register: its MSB feeds the step
    // while resolved quotient bits enter at the LSB.
    udiv_step u_step (
        .rem_in  (r_reg),
        .bit_in  (q_reg[DIVIDEND_W-1]),
        .divisor (d_reg),
        .rem_out (r_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            q_reg  <= '0;
            r_reg  <= '0;
            d_reg  <= '0;
            dz_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_reg <= divisor;
                        if (divisor == '0) begin
                            q_reg  <= QUOT_ONES;
                            r_reg  <= dividend[DIVISOR_W-1:0];
                            dz_reg <= 1'b1;
                            cnt    <= '0;
                        end else begin
                            q_reg  <= dividend;
                            r_reg  <= '0;
                            dz_reg <= 1'b0;
                            cnt    <= CNT_W'(DIVIDEND_W);
                        end
                    end
                end
                CALC: begin
                    q_reg <= {q_reg[DIVIDEND_W-2:0], q_bit};
                    r_reg <= r_next;
                    cnt   <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = q_reg;
    assign remainder = r_reg;
    assign div_zero  = dz_reg;

endmodule

// File: tb/tb_seq_udiv_12_6.sv
module tb_seq_udiv_12_6;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] dividend;
    logic [5:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] quotient;
    logic [5:0]  remainder;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    seq_udiv_12_6 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] dvd;
        logic [5:0]  dvs;
        logic [11:0] q;
        logic [5:0]  r;
        logic        dz;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    // Acceptance happens at rising edge E0; valid_edge counts rising edges
    // after E0 until out_valid is seen (12 for a real division, 0 for a
    // zero divisor, i.e. out_valid already high in the cycle after E0).
    // stall < 0 leaves the result pending in DONE.
    task automatic do_div(input logic [11:0] dvd, input logic [5:0] dvs,
                          input logic [11:0] eq, input logic [5:0] er, input logic edz,
                          input int stall, input string name);
        int w;
        int valid_edge;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({name, ".in_ready_wait"}, 32'(in_ready), 32'd1);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        dividend   = $urandom;
        divisor    = $urandom;
        valid_edge = 0;
        while (!out_valid && valid_edge < 40) begin
            @(negedge clk);
            valid_edge++;
        end
        chk({name, ".valid_edge"}, 32'(valid_edge), edz ? 32'd0 : 32'd12);
        chk({name, ".quotient"}, 32'(quotient), 32'(eq));
        chk({name, ".remainder"}, 32'(remainder), 32'(er));
        chk({name, ".div_zero"}, 32'(div_zero), 32'(edz));
        chk({name, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        if (stall >= 0) begin
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk({name, ".stall_q"}, 32'(quotient), 32'(eq));
                chk({name, ".stall_v"}, 32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({name, ".handoff_ready"}, 32'(in_ready), 32'd1);
            chk({name, ".handoff_valid"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [11:0] rd;
        logic [5:0]  rv;

        vecs[0]  = '{12'd3969, 6'd63, 12'd63,   6'd0,  1'b0};
        vecs[1]  = '{12'd4095, 6'd1,  12'd4095, 6'd0,  1'b0};
        vecs[2]  = '{12'd100,  6'd7,  12'd14,   6'd2,  1'b0};
        vecs[3]  = '{12'd5,    6'd0,  12'd4095, 6'd5,  1'b1};
        vecs[4]  = '{12'd4000, 6'd9,  12'd444,  6'd4,  1'b0};
        vecs[5]  = '{12'd0,    6'd5,  12'd0,    6'd0,  1'b0};
        vecs[6]  = '{12'd4095, 6'd63, 12'd65,   6'd0,  1'b0};
        vecs[7]  = '{12'd1000, 6'd33, 12'd30,   6'd10, 1'b0};
        vecs[8]  = '{12'd4095, 6'd0,  12'd4095, 6'd63, 1'b1};
        vecs[9]  = '{12'd62,   6'd63, 12'd0,    6'd62, 1'b0};
        vecs[10] = '{12'd2048, 6'd2,  12'd1024, 6'd0,  1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.quotient", 32'(quotient), 32'd0);
        chk("reset.remainder", 32'(remainder), 32'd0);
        chk("reset.div_zero", 32'(div_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            do_div(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dz, 0,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: result held 5 cycles while in_valid pulses are ignored.
        do_div(12'd100, 6'd7, 12'd14, 6'd2, 1'b0, -1, "bp");
        for (int s = 0; s < 5; s++) begin
            in_valid = s[0] ? 1'b0 : 1'b1;
            dividend = 12'd50;
            divisor  = 6'd3;
            @(negedge clk);
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk("bp.quotient", 32'(quotient), 32'd14);
            chk("bp.remainder", 32'(remainder), 32'd2);
            chk("bp.div_zero", 32'(div_zero), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.release_ready", 32'(in_ready), 32'd1);
        chk("bp.release_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("bp.no_accept", 32'(in_ready), 32'd1);

        // Reset in the middle of an iteration sequence.
        dividend = 12'd4000;
        divisor  = 6'd9;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst.busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.quotient", 32'(quotient), 32'd0);
        chk("midrst.remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_div(12'd4000, 6'd9, 12'd444, 6'd4, 1'b0, 0, "after_rst");

        // Random operands with random result backpressure.
        for (int i = 0; i < 400; i++) begin
            rd = 12'($urandom);
            rv = ($urandom_range(0, 15) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            if (rv == 6'd0) begin
                do_div(rd, rv, 12'hFFF, rd[5:0], 1'b1, int'($urandom_range(0, 3)), "rand");
            end else begin
                do_div(rd, rv, 12'(rd / 12'(rv)), 6'(rd % 12'(rv)), 1'b0,
                       int'($urandom_range(0, 3)), "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
